// File: rtl/contador_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// contador_ctrl_pkg
//   Shared definitions for the contador read controller: FSM state encoding,
//   state width and default parameter values used by contador_ctrl and its
//   optional scan sub-module (built only with CONT_CTRL_SCAN_EN defined).
// -----------------------------------------------------------------------------
package contador_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   localparam int DEF_CNT_WIDTH   = 8;
   localparam int DEF_NUM_CNT     = 4;
   localparam int DEF_IDX_WIDTH   = 2;
   localparam int DEF_TIMEOUT     = 4;
   localparam int DEF_SCAN_PERIOD = 16;

   // Width of a counter that must hold values 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/contador_ctrl_scan.sv
// -----------------------------------------------------------------------------
// contador_ctrl_scan
//   Background scan engine for contador_ctrl (only instantiated when
//   CONT_CTRL_SCAN_EN is defined). Counts consecutive idle cycles, raises a
//   scan trigger after SCAN_PERIOD of them, keeps the round-robin scan
//   pointer and the per-counter snapshot registers.
//
// Ports
//   clk, reset    clock, synchronous active-high reset
//   idle_i        controller FSM is in IDLE
//   host_req_i    host read request this cycle (restarts the idle timer)
//   cap_i         scan read got valid data this cycle (WAIT -> RESP edge)
//   done_i        scan read is in its RESP cycle (success or timeout)
//   cap_data_i    data to store into snapshot entry ptr_o
//   trig_o        launch a scan read of counter ptr_o
//   ptr_o         current scan pointer
//   snap_data_o   flattened snapshot, entry i at [i*CNT_WIDTH +: CNT_WIDTH]
//   snap_upd_o    one-hot pulse in the RESP cycle of a successful scan
// -----------------------------------------------------------------------------
module contador_ctrl_scan
   import contador_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int NUM_CNT     = DEF_NUM_CNT,
   parameter int IDX_WIDTH   = DEF_IDX_WIDTH,
   parameter int SCAN_PERIOD = DEF_SCAN_PERIOD
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         idle_i,
   input  logic                         host_req_i,
   input  logic                         cap_i,
   input  logic                         done_i,
   input  logic [CNT_WIDTH-1:0]         cap_data_i,
   output logic                         trig_o,
   output logic [IDX_WIDTH-1:0]         ptr_o,
   output logic [NUM_CNT*CNT_WIDTH-1:0] snap_data_o,
   output logic [NUM_CNT-1:0]           snap_upd_o
);

   localparam int PW = cnt_w(SCAN_PERIOD);

   logic [PW-1:0]                       idle_cnt_q, idle_cnt_d;
   logic [IDX_WIDTH-1:0]                ptr_q, ptr_d;
   logic [NUM_CNT-1:0][CNT_WIDTH-1:0]   snap_q, snap_d;
   logic [NUM_CNT-1:0]                  upd_q, upd_d;

   // The SCAN_PERIOD-th consecutive idle cycle is the trigger cycle.
   assign trig_o = idle_i && (idle_cnt_q == PW'(SCAN_PERIOD - 1));

   always_comb begin
      idle_cnt_d = idle_cnt_q + 1'b1;
      ptr_d      = ptr_q;
      snap_d     = snap_q;
      upd_d      = '0;
      // Any busy cycle, host request or fired trigger restarts the timer.
      if (!idle_i || host_req_i || trig_o) idle_cnt_d = '0;
      // Snapshot is written on the edge into RESP so the new value and the
      // update pulse appear together in the RESP cycle.
      if (cap_i) begin
         snap_d[ptr_q] = cap_data_i;
         upd_d         = NUM_CNT'(1) << ptr_q;
      end
      // Pointer moves on after every scan read, including timeouts.
      if (done_i) ptr_d = (ptr_q == IDX_WIDTH'(NUM_CNT - 1)) ? '0 : ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt_q <= '0;
         ptr_q      <= '0;
         snap_q     <= '0;
         upd_q      <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         ptr_q      <= ptr_d;
         snap_q     <= snap_d;
         upd_q      <= upd_d;
      end
   end

   assign ptr_o       = ptr_q;
   assign snap_data_o = snap_q;
   assign snap_upd_o  = upd_q;

endmodule

// File: rtl/contador_ctrl.sv
// -----------------------------------------------------------------------------
// contador_ctrl
//   Shares one host read port among NUM_CNT contador instances. A host read
//   strobes the selected counter (cnt_req + one-hot cnt_idx) for one cycle,
//   waits up to TIMEOUT cycles for its valid, and returns the value with a
//   one-cycle rd_valid pulse. Out-of-range indices and silent counters are
//   answered with rd_err=1, rd_data=0.
//   Optional feature macro: CONT_CTRL_SCAN_EN -- periodic background scan of
//   all counters into snap_data/snap_upd. Without it those ports are 0.
//
// Ports
//   clk, reset   clock, synchronous active-high reset
//   rd_req       host read request (sampled only while rd_ready=1)
//   rd_idx       counter index
//   rd_ready     controller idle and able to accept
//   rd_valid     one-cycle response pulse
//   rd_data      captured count (0 on error)
//   rd_err       qualifies rd_valid: timeout or index out of range
//   cnt_req      shared request strobe to all counters
//   cnt_idx      one-hot counter select
//   cnt_valid    per-counter valid
//   cnt_data     per-counter data, counter i at [i*CNT_WIDTH +: CNT_WIDTH]
//   snap_data    scan snapshot (scan build only)
//   snap_upd     one-hot snapshot update pulse (scan build only)
// -----------------------------------------------------------------------------
module contador_ctrl
   import contador_ctrl_pkg::*;
#(
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int NUM_CNT     = DEF_NUM_CNT,
   parameter int IDX_WIDTH   = DEF_IDX_WIDTH,
   parameter int TIMEOUT     = DEF_TIMEOUT,
   parameter int SCAN_PERIOD = DEF_SCAN_PERIOD
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         rd_req,
   input  logic [IDX_WIDTH-1:0]         rd_idx,
   output logic                         rd_ready,
   output logic                         rd_valid,
   output logic [CNT_WIDTH-1:0]         rd_data,
   output logic                         rd_err,
   output logic                         cnt_req,
   output logic [NUM_CNT-1:0]           cnt_idx,
   input  logic [NUM_CNT-1:0]           cnt_valid,
   input  logic [NUM_CNT*CNT_WIDTH-1:0] cnt_data,
   output logic [NUM_CNT*CNT_WIDTH-1:0] snap_data,
   output logic [NUM_CNT-1:0]           snap_upd
);

   localparam int TO_W = cnt_w(TIMEOUT);

   state_e                state_q, state_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [TO_W-1:0]       to_q, to_d;
   logic [CNT_WIDTH-1:0]  data_q, data_d;
   logic                  err_q, err_d;
   logic                  scan_q, scan_d;   // current read is an internal scan

   logic                  sel_valid;
   logic [CNT_WIDTH-1:0]  sel_data;
   logic                  in_range;
   logic                  scan_trig;
   logic [IDX_WIDTH-1:0]  scan_ptr;

   assign in_range = (int'(rd_idx) < NUM_CNT);

   // Only the latched counter's valid/data matter; others are ignored.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (idx_q == IDX_WIDTH'(i)) begin
            sel_valid = cnt_valid[i];
            sel_data  = cnt_data[i*CNT_WIDTH +: CNT_WIDTH];
         end
      end
   end

`ifdef CONT_CTRL_SCAN_EN
   contador_ctrl_scan #(
      .CNT_WIDTH   (CNT_WIDTH),
      .NUM_CNT     (NUM_CNT),
      .IDX_WIDTH   (IDX_WIDTH),
      .SCAN_PERIOD (SCAN_PERIOD)
   ) u_scan (
      .clk         (clk),
      .reset       (reset),
      .idle_i      (state_q == ST_IDLE),
      .host_req_i  (rd_req),
      .cap_i       (scan_q && (state_q == ST_WAIT) && sel_valid),
      .done_i      (scan_q && (state_q == ST_RESP)),
      .cap_data_i  (sel_data),
      .trig_o      (scan_trig),
      .ptr_o       (scan_ptr),
      .snap_data_o (snap_data),
      .snap_upd_o  (snap_upd)
   );
`else
   assign scan_trig = 1'b0;
   assign scan_ptr  = '0;
   assign snap_data = '0;
   assign snap_upd  = '0;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      to_d     = to_q;
      data_d   = data_q;
      err_d    = err_q;
      scan_d   = scan_q;
      rd_ready = 1'b0;
      rd_valid = 1'b0;
      rd_data  = '0;
      rd_err   = 1'b0;
      cnt_req  = 1'b0;
      cnt_idx  = '0;
      unique case (state_q)
         ST_IDLE: begin
            rd_ready = 1'b1;
            // Host request beats a coincident scan trigger.
            if (rd_req) begin
               scan_d = 1'b0;
               if (in_range) begin
                  idx_d   = rd_idx;
                  state_d = ST_REQ;
               end else begin
                  data_d  = '0;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end else if (scan_trig) begin
               idx_d   = scan_ptr;
               scan_d  = 1'b1;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            cnt_req = 1'b1;
            cnt_idx = NUM_CNT'(1) << idx_q;
            to_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (sel_valid) begin
               data_d  = sel_data;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (to_q == TO_W'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         ST_RESP: begin
            // Scan reads complete silently on the host side.
            rd_valid = !scan_q;
            rd_err   = err_q && !scan_q;
            rd_data  = scan_q ? '0 : data_q;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         to_q    <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         scan_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         to_q    <= to_d;
         data_q  <= data_d;
         err_q   <= err_d;
         scan_q  <= scan_d;
      end
   end

endmodule
